// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Program counter for a simple fetch stage. Every cycle one next-pc source is
// chosen by fixed priority: reset, trap, jump, branch, stall, halt check,
// then the sequential increment. A redirect is taken only if its target is a
// multiple of STEP. A misaligned redirect leaves pc and state alone, pulses
// misalign for one cycle, and does not hand over to a lower-priority redirect.
// Sequential fetch stops at HALT_ADDR (when HALT_EN is set). The unit then
// sits in HALT until an aligned redirect or a reset arrives.
//
// Parameters
//   XLEN        address width in bits (up to 64 for the address parameters)
//   RESET_ADDR  pc value loaded by reset
//   STEP        sequential increment, 1, 2 or 4 address units
//   HALT_ADDR   address at which sequential fetch stops
//   HALT_EN     1 enables the HALT_ADDR stop, 0 disables it
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   rst          synchronous active-high reset
//   stall        hold pc this cycle (no effect while halted)
//   trap_en      redirect to trap_vec (highest redirect priority)
//   trap_vec     absolute trap target
//   jump_en      redirect to jump_target
//   jump_target  absolute jump target
//   branch_en    redirect to pc + branch_off
//   branch_off   signed two's-complement branch offset
//   pc           current fetch address (registered)
//   pc_plus      pc + STEP, combinational, wraps modulo 2^XLEN
//   halted       high while in HALT (decoded from the state register)
//   misalign     registered one-cycle pulse for a rejected redirect
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter longint unsigned RESET_ADDR = 0,
  parameter int unsigned     STEP       = 4,
  parameter longint unsigned HALT_ADDR  = 80,
  parameter bit              HALT_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_off,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            halted,
  output logic            misalign
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // The halt address is compared at a width that holds both pc and the full
  // 64-bit parameter. An address beyond 2^XLEN then never matches, and is
  // not aliased onto a reachable pc by truncation.
  localparam int unsigned     CMP_W      = (XLEN > 64) ? XLEN : 64;
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] RESET_V    = XLEN'(RESET_ADDR);
  localparam logic [CMP_W-1:0] HALT_CMP  = CMP_W'(HALT_ADDR);

  state_t          state;
  logic            redirect_req;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_ok;
  logic            halt_hit;

  // Pick the winning redirect target. Trap beats jump, and jump beats branch.
  // Only the winner's target is checked for alignment. A misaligned winner
  // therefore blocks the lower-priority redirects instead of yielding to them.
  always_comb begin
    redirect_req = trap_en | jump_en | branch_en;
    redirect_tgt = pc + branch_off;
    if (trap_en) begin
      redirect_tgt = trap_vec;
    end else if (jump_en) begin
      redirect_tgt = jump_target;
    end
  end

  // A target is aligned when it is a multiple of STEP. STEP is restricted to
  // a power of two, so the alignment test only needs the low bits.
  assign redirect_ok = ((redirect_tgt & ALIGN_MASK) == '0);

  // The halt stop only fires when enabled and pc lands exactly on HALT_ADDR.
  assign halt_hit = HALT_EN && (CMP_W'(pc) == HALT_CMP);

  // The sequential successor wraps naturally at 2^XLEN.
  assign pc_plus = pc + STEP_V;

  // The whole next-state decision lives in one register block:
  //   - Reset wins over everything.
  //   - Then comes the winning redirect, accepted or rejected.
  //   - Then the RUN/HALT behaviour.
  // misalign is cleared on every path except a rejected redirect, so it can
  // only ever be a single-cycle pulse per rejected request. Stall is looked
  // at only in RUN; in HALT the pc holds anyway, so stall has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_V;
      state    <= RUN;
      misalign <= 1'b0;
    end else if (redirect_req) begin
      if (redirect_ok) begin
        pc       <= redirect_tgt;
        state    <= RUN;
        misalign <= 1'b0;
      end else begin
        misalign <= 1'b1;
      end
    end else begin
      misalign <= 1'b0;
      case (state)
        RUN: begin
          if (!stall) begin
            if (halt_hit) begin
              state <= HALT;
            end else begin
              pc <= pc_plus;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // halted is decoded straight from the state flop, so no input reaches it
  // combinationally.
  assign halted = (state == HALT);

endmodule
